babbage_poly_engine: RTL
========================

// Module: babbage_poly_engine
// PURPOSE
//  Generalised Babbage difference engine. Evaluates any polynomial of degree
//  <= ORDER at integer point n using only additions (finite differences).
//  Software seeds the initial difference table d[0..ORDER] once, then issues
//  start/n requests. Sits as a reusable arithmetic core behind a simple
//  start/rdy/done handshake.
// PARAMETERS
//  ORDER  3   polynomial degree supported; ORDER+1 difference registers
//  DW     24  width of every difference register and of f_out (unsigned)
//  NW     8   width of n (max iterations 2**NW-1)
// PORTS
//  clk        in   1         clock
//  arst_n     in   1         reset, asynchronous, active-low
//  seed_we    in   1         write seed register seed[seed_idx]
//  seed_idx   in   clog2(ORDER+1)  seed index 0..ORDER (0 = f(0))
//  seed_data  in   DW        seed value
//  start      in   1         start evaluation (accepted only when rdy)
//  n          in   NW        evaluation point, sampled with start
//  f_out      out  DW        result f(n); valid while done, held until next start
//  ovf        out  1         sticky: carry out of d[0] addition during run
//  done       out  1         one-cycle pulse, result valid
//  rdy        out  1         high in IDLE
//  strm_valid out  1         [BABBAGE_STREAM_EN only] intermediate f(k) valid
//  strm_data  out  DW        [BABBAGE_STREAM_EN only] intermediate f(k)
// BEHAVIOUR
//  - Reset: state IDLE, seed[*]=0, work d[*]=0, f_out=0, ovf=0, done=0, rdy=1,
//    strm_valid=0, strm_data=0.
//  - Two banks: seed[0..ORDER] (persistent) and work d[0..ORDER] (per run).
//  - seed_we honoured only in IDLE; ignored in CALC/DONE. seed_idx>ORDER ignored.
//  - seed_we and start in same IDLE cycle: seed write lands, start uses OLD seeds.
//  - FSM IDLE->CALC->DONE->IDLE.
//    IDLE: on start: d<=seed, cnt<=n, ovf<=0; go CALC, or DONE if n==0.
//    CALC: per cycle, all i<ORDER in parallel: d[i]<=d[i]+d[i+1] (old values);
//      d[ORDER] constant; cnt<=cnt-1; go DONE when cnt==1.
//    DONE: done=1 for exactly one cycle; go IDLE.
//  - f_out = d[0]. Latency: start edge to done = n+1 clocks (n=0 -> 1 clock).
//  - Arithmetic unsigned, modulo 2**DW; ovf set if d[0]+d[1] carries out of DW
//    bits in any CALC cycle; carries in higher-index adds do not set ovf.
//  - start while not rdy ignored (no queueing). Reset mid-run aborts to reset
//    values; seeds are lost.
// CONFIGURATION
//  BABBAGE_STREAM_EN defined: strm_valid/strm_data exist; strm_valid high in
//    the cycle after each CALC update with strm_data=f(k), k=1..n in order
//    (n pulses, last one coincides with done); n==0 gives no pulse.
//  Undefined: ports absent, no stream logic; behaviour otherwise identical.
// TESTING
//  1 seed d=[5,5,4,0], start n=4 -> done 5 clocks later, f_out=49, ovf=0.
//  2 same seeds, n=0 -> done 1 clock after start, f_out=5.
//  3 cubic seed d=[0,1,6,6], n=5 -> f_out=125; n=10 -> f_out=1000.
//  4 seed d=[0xFFFFFF,1,0,0], n=1 -> f_out=0, ovf=1; next run n=1 with
//    d0=0 -> ovf=0.
//  5 start and seed_we pulsed during CALC -> ignored; result unchanged;
//    arst_n low mid-CALC -> rdy=1, done=0, f_out=0, seeds=0.
//  6 BABBAGE_STREAM_EN, d=[5,5,4,0], n=3 -> strm_data 10,19,32 on consecutive
//    cycles, last with done.

Source files
------------

// File: rtl/babbage_poly_engine.sv
// Finite-difference polynomial evaluator: seeded difference table advanced n times by additions only.
// Optional BABBAGE_STREAM_EN exposes every intermediate f(k) on strm_valid/strm_data.
module babbage_poly_engine #(
  parameter int ORDER = 3,
  parameter int DW    = 24,
  parameter int NW    = 8
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         seed_we,
  input  logic [$clog2(ORDER+1)-1:0]   seed_idx,
  input  logic [DW-1:0]                seed_data,
  input  logic                         start,
  input  logic [NW-1:0]                n,
  output logic [DW-1:0]                f_out,
  output logic                         ovf,
  output logic                         done,
  output logic                         rdy
`ifdef BABBAGE_STREAM_EN
  ,
  output logic                         strm_valid,
  output logic [DW-1:0]                strm_data
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] seed [ORDER+1];
  logic [DW-1:0] d    [ORDER+1];
  logic [NW-1:0] cnt;
  logic [DW:0]   sum0;

  // d[0] add is kept one bit wider so its carry can feed the sticky overflow
  assign sum0  = {1'b0, d[0]} + {1'b0, d[1]};
  assign rdy   = (state == IDLE);
  assign done  = (state == DONE);
  assign f_out = d[0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n == '0) ? DONE : CALC;
      CALC:    if (cnt == NW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i <= ORDER; i++) seed[i] <= '0;
    end else if (rdy && seed_we && int'(seed_idx) <= ORDER) begin
      seed[seed_idx] <= seed_data;
    end
  end

  // Work bank copies the pre-write seeds, so a same-cycle seed write only affects later runs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i <= ORDER; i++) d[i] <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i <= ORDER; i++) d[i] <= seed[i];
          cnt <= n;
          ovf <= 1'b0;
        end
        CALC: begin
          d[0] <= sum0[DW-1:0];
          for (int i = 1; i < ORDER; i++) d[i] <= d[i] + d[i+1];
          cnt <= cnt - NW'(1);
          ovf <= ovf | sum0[DW];
        end
        default: ;
      endcase
    end
  end

`ifdef BABBAGE_STREAM_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      strm_valid <= 1'b0;
      strm_data  <= '0;
    end else begin
      strm_valid <= (state == CALC);
      if (state == CALC) strm_data <= sum0[DW-1:0];
    end
  end
`endif

endmodule
